// File: rtl/mm_vga_regbank.sv
// mm_vga_regbank: MMIO colour shadow/active register bank with vblank-synchronised commit.
// Define MM_VGA_FRAME_IRQ_EN to build the frame counter and frame_irq.
module mm_vga_regbank #(
  parameter int N = 32,
  parameter logic [N-1:0] BASE_ADDR = 32'h80000000,
  parameter int NUM_CH = 3,
  parameter int CH_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [N-1:0]           addr,
  input  logic [N-1:0]           data,
  output logic [N-1:0]           q,
  input  logic                   vblank,
  output logic [NUM_CH*CH_W-1:0] color_out,
  output logic                   frame_irq
);
  logic [N-1:0] off, q_q, q_d, frame_v;
  logic [N-1:0] shadow_q [NUM_CH];
  logic [N-1:0] shadow_d [NUM_CH];
  logic [CH_W-1:0] active_q [NUM_CH];
  logic [CH_W-1:0] active_d [NUM_CH];
  logic mode_q, mode_d, pending_q, pending_d, vblank_q, vblank_d, irq_en_v;
  logic tick, ctrl_wr, commit_req, commit_all;
  always_comb begin
    off = addr - BASE_ADDR;
    tick = vblank & ~vblank_q;
    ctrl_wr = we && off == N'(NUM_CH);
    commit_req = ctrl_wr & data[1];
    // pending implies sync mode, so a CTRL write clearing MODE flushes it
    commit_all = (tick & pending_q) | (ctrl_wr & pending_q & ~data[0]) | (commit_req & (~data[0] | tick));
    mode_d = reset ? 1'b0 : ctrl_wr ? data[0] : mode_q;
    pending_d = reset ? 1'b0 : commit_all ? 1'b0 : commit_req ? 1'b1 : pending_q;
    vblank_d = reset ? 1'b1 : vblank;
    q_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      shadow_d[k] = reset ? '0 : (we && off == N'(k)) ? data : shadow_q[k];
      active_d[k] = reset ? '0 : commit_all ? shadow_q[k][CH_W-1:0] :
                    (we && off == N'(k) && !mode_q) ? data[CH_W-1:0] : active_q[k];
      if (off == N'(k)) q_d = shadow_q[k];
    end
    if (off == N'(NUM_CH)) q_d = {{(N-3){1'b0}}, irq_en_v, 1'b0, mode_q};
    if (off == N'(NUM_CH + 1)) q_d = frame_v;
    if (off == N'(NUM_CH + 2)) q_d = {{(N-1){1'b0}}, pending_q};
    q_d = reset ? '0 : q_d;
    color_out = '0;
    for (int k = 0; k < NUM_CH; k++) color_out[k*CH_W +: CH_W] = active_q[k];
  end
  always_ff @(posedge clock) begin
    shadow_q <= shadow_d;
    active_q <= active_d;
    mode_q <= mode_d;
    pending_q <= pending_d;
    vblank_q <= vblank_d;
    q_q <= q_d;
  end
  assign q = q_q;
`ifdef MM_VGA_FRAME_IRQ_EN
  logic [N-1:0] frame_q, frame_d;
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  always_comb begin
    frame_d = reset ? '0 : frame_q + N'(tick);
    irq_en_d = reset ? 1'b0 : ctrl_wr ? data[2] : irq_en_q;
    irq_d = reset ? 1'b0 : tick & irq_en_q;
  end
  always_ff @(posedge clock) begin
    frame_q <= frame_d;
    irq_en_q <= irq_en_d;
    irq_q <= irq_d;
  end
  assign frame_v = frame_q;
  assign irq_en_v = irq_en_q;
  assign frame_irq = irq_q;
`else
  assign frame_v = '0;
  assign irq_en_v = 1'b0;
  assign frame_irq = 1'b0;
`endif
endmodule

// File: tb/tb_mm_vga_regbank.sv
// tb_mm_vga_regbank: directed and randomized checks of mm_vga_regbank against an in-bench reference model.
module tb_mm_vga_regbank;
  localparam logic [31:0] B = 32'h80000000;
  logic clock = 1'b0, reset = 1'b1, we = 1'b0, vblank = 1'b0;
  logic [31:0] addr = '0, data = '0, q;
  logic [11:0] color_out;
  logic frame_irq;
  int checks = 0, failures = 0, irq_count = 0;
  logic [31:0] m_sh [3];
  logic [3:0] m_act [3];
  logic [31:0] m_frame, m_q;
  bit m_mode, m_irq_en, m_pend, m_vq, m_irq;

  always #5 clock = ~clock;

  mm_vga_regbank dut (
    .clock(clock), .reset(reset), .we(we), .addr(addr), .data(data), .q(q),
    .vblank(vblank), .color_out(color_out), .frame_irq(frame_irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: apply one clock edge of the register map rules to the model state.
  task automatic model_step();
    logic [31:0] off, old_sh [3];
    bit tick, commit;
    if (reset) begin
      foreach (m_sh[k]) begin m_sh[k] = '0; m_act[k] = '0; end
      m_mode = 0; m_irq_en = 0; m_pend = 0; m_vq = 1; m_frame = '0; m_q = '0; m_irq = 0;
      return;
    end
    off = addr - B;
    m_q = (off < 3) ? m_sh[off] : (off == 3) ? {29'd0, m_irq_en, 1'b0, m_mode} :
          (off == 4) ? m_frame : (off == 5) ? {31'd0, m_pend} : 32'd0;
    tick = vblank && !m_vq;
    m_vq = vblank;
    m_irq = 0;
`ifdef MM_VGA_FRAME_IRQ_EN
    m_irq = tick && m_irq_en;
    if (tick) m_frame = m_frame + 1;
`endif
    old_sh = m_sh;
    commit = 0;
    if (we && off < 3) begin
      m_sh[off] = data;
      if (!m_mode) m_act[off] = data[3:0];
    end
    if (we && off == 3) begin
      if (m_mode && !data[0] && m_pend) commit = 1;
      if (data[1]) begin
        if (!data[0] || tick) commit = 1;
        else m_pend = 1;
      end
      m_mode = data[0];
`ifdef MM_VGA_FRAME_IRQ_EN
      m_irq_en = data[2];
`endif
    end
    if (tick && m_pend) commit = 1;
    if (commit) begin
      foreach (m_act[k]) m_act[k] = old_sh[k][3:0];
      m_pend = 0;
    end
  endtask

  task automatic cyc(input bit w, input logic [31:0] a, input logic [31:0] d, input bit v);
    we = w; addr = a; data = d; vblank = v;
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("q", q, m_q);
    chk("color_out", {20'd0, color_out}, {20'd0, m_act[2], m_act[1], m_act[0]});
    chk("frame_irq", {31'd0, frame_irq}, {31'd0, m_irq});
    if (frame_irq === 1'b1) irq_count++;
  endtask

  initial begin
    bit vb;
    logic [31:0] a;
    reset = 1; cyc(0, B, 0, 0); cyc(0, B, 0, 0); reset = 0;
    chk("reset_color", {20'd0, color_out}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, B + k, 0, 0);
      chk("reset_read", q, 32'h0);
    end
    cyc(1, B, 32'h1F, 0);
    chk("imm_color", {20'd0, color_out}, 32'h00F);
    cyc(0, B, 0, 0);
    chk("imm_read", q, 32'h1F);
    reset = 1; cyc(0, B, 0, 0); reset = 0;
    cyc(1, B + 3, 1, 0); cyc(1, B, 5, 0); cyc(1, B + 1, 6, 0); cyc(1, B + 2, 7, 0);
    chk("sync_hold", {20'd0, color_out}, 32'h0);
    cyc(1, B + 3, 3, 0);
    cyc(0, B + 5, 0, 0);
    chk("status_pend", q, 32'h1);
    cyc(0, B + 5, 0, 1);
    chk("sync_commit", {20'd0, color_out}, 32'h765);
    chk("status_pre_edge", q, 32'h1);
    cyc(0, B + 5, 0, 1);
    chk("status_clr", q, 32'h0);
    cyc(0, B, 0, 0);
    cyc(1, B + 3, 3, 0);
    cyc(1, B, 9, 1);
    chk("wr_tick_active", {20'd0, color_out}, 32'h765);
    cyc(0, B + 5, 0, 0);
    chk("wr_tick_pend", q, 32'h0);
    cyc(0, B, 0, 0);
    chk("wr_tick_shadow", q, 32'h9);
    cyc(1, B + 1, 32'hA, 0);
    cyc(1, B + 3, 3, 1);
    chk("commit_tick", {20'd0, color_out}, 32'h7A9);
    cyc(0, B + 5, 0, 1);
    chk("commit_tick_pend", q, 32'h0);
    cyc(0, B, 0, 0);
    reset = 1; cyc(0, B, 0, 0); reset = 0;
    cyc(1, B + 3, 4, 0);
    irq_count = 0;
    repeat (3) begin cyc(0, B, 0, 1); cyc(0, B, 0, 0); cyc(0, B, 0, 0); end
    cyc(0, B + 4, 0, 0);
`ifdef MM_VGA_FRAME_IRQ_EN
    chk("frame_cnt", q, 32'd3);
    chk("irq_pulses", irq_count, 32'd3);
`else
    chk("frame_cnt", q, 32'd0);
    chk("irq_pulses", irq_count, 32'd0);
`endif
    cyc(1, B + 3, 3, 0);
    reset = 1; cyc(0, B, 0, 1); cyc(0, B, 0, 1); reset = 0;
    cyc(0, B + 4, 0, 1);
    chk("rst_frame", q, 32'h0);
    cyc(0, B + 5, 0, 1);
    chk("rst_status", q, 32'h0);
    chk("rst_color", {20'd0, color_out}, 32'h0);
    cyc(1, B + 32'h10, 32'hFFFF, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, B + k, 0, 0);
      chk("unmapped_wr", q, 32'h0);
    end
    vb = 0;
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) vb = !vb;
      a = ($urandom_range(0, 9) == 0) ? $urandom : B + $urandom_range(0, 6);
      cyc($urandom_range(0, 1) == 1, a, $urandom, vb);
    end
    reset = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mm_vga_regbank.md
# mm_vga_regbank

Memory-mapped colour register bank for the VGA path, sitting on the CPU data bus beside other MMIO peripherals and driving the pixel-colour inputs of the VGA output stage. It generalises the fixed three-register colour block to NUM_CH channels of CH_W bits each. Each channel has a CPU-visible shadow register and a separate active register. Shadow-to-active commit is either immediate or synchronised to the start of vertical blanking, so colour changes never tear mid-frame. Bus reads are registered, and the block provides a frame counter and a frame interrupt.

## Interface

Parameters:
- N, 32: bus data/address width.
- BASE_ADDR, 32'h80000000: address of channel 0; registers at consecutive addresses BASE_ADDR+k.
- NUM_CH, 3: number of colour channels (1..8).
- CH_W, 4: bits per channel driven to the VGA stage (1..N).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- we, in, 1: bus write enable.
- addr, in, N: bus address.
- data, in, N: bus write data.
- q, out, N: registered read data.
- vblank, in, 1: vertical-blank level from VGA timing; synchronous to clock.
- color_out, out, NUM_CH*CH_W: active channels; channel k at [k*CH_W +: CH_W].
- frame_irq, out, 1: one-cycle frame pulse.

## Operation

Register map, offset = addr - BASE_ADDR; every decode is a full N-bit equality compare:
- 0..NUM_CH-1, SHADOW[k]: R/W, N bits.
- NUM_CH, CTRL: R/W.
  - bit0 MODE: 0 = immediate, 1 = vblank-sync.
  - bit1 COMMIT: write-1 requests a commit; self-clearing, always reads 0.
  - bit2 IRQ_EN.
  - Other bits are written as ignored and read as 0.
- NUM_CH+1, FRAME: RO, N-bit count of vblank rising edges; wraps at 2^N-1 -> 0.
- NUM_CH+2, STATUS: RO, bit0 = PENDING.
- Unmapped writes are ignored; unmapped reads return 0; writes to RO registers are ignored.

Frame tick:
- Asserted in a cycle when vblank=1 and vblank_q=0. vblank_q is vblank registered.
- vblank_q resets to 1, so vblank held high out of reset produces no tick.

Immediate mode (MODE=0):
- A write to SHADOW[k] updates both SHADOW[k] and active[k] at the same edge.
- active[k] is SHADOW[k][CH_W-1:0].

Sync mode (MODE=1):
- Writes update SHADOW only.
- A CTRL write with COMMIT=1 sets PENDING.
- On a tick with PENDING=1, every active[k] loads from its SHADOW[k] and PENDING clears.

Boundary cases:
- COMMIT write in the same cycle as a tick: the commit happens at that edge and PENDING stays 0.
- SHADOW write in the same cycle as a commit tick: active takes the pre-write SHADOW value; the new value remains in SHADOW; PENDING is unaffected.
- CTRL write changing MODE 1->0 while PENDING=1: all active registers load SHADOW at that edge and PENDING clears.
- COMMIT=1 written while MODE=0 (or while MODE is being written to 0): all active registers load SHADOW; PENDING stays 0.
- PENDING already set plus another COMMIT: no change; commits do not queue.

Frame interrupt: frame_irq=1 for exactly the cycle after a tick when IRQ_EN=1; otherwise 0.

Reset values, all at the next edge with reset high:
- SHADOW, active, CTRL, PENDING, FRAME, q, frame_irq: 0.
- color_out: 0.
- vblank_q: 1.
- Reset mid-frame or with PENDING set discards the pending commit.

## Timing

- Writes: take effect at the rising edge where we=1; color_out reflects an immediate-mode write on the following cycle.
- Reads: q = register[addr] sampled at edge t, valid during cycle t+1. One cycle of latency, no read enable; q updates every cycle.
  - A read and write to the same address in the same cycle returns the old value.
  - STATUS and FRAME reads return the pre-edge value.
- Sync commit: color_out changes at the edge ending the first cycle with vblank=1. frame_irq rises at the same edge.
- FRAME increments at the same edge as the tick.
- No back-pressure; the bus is always ready.

## Configuration

- MM_VGA_FRAME_IRQ_EN defined: FRAME counter and frame_irq behave as above.
- Not defined: no frame counter; FRAME reads 0; frame_irq is tied 0; IRQ_EN is read-as-0/write-ignored.
- In both builds: ports are unchanged, and the vblank edge detector and sync commit remain present.

## Test plan

All scenarios use defaults (NUM_CH=3, CH_W=4, BASE_ADDR 32'h80000000).

- Reset, then read all addresses 80000000..80000004 -> q=0 one cycle after each; color_out=12'h000.
- Immediate mode: write 32'h1F to 80000000 -> next cycle color_out[3:0]=4'hF. Read 80000000 -> q=32'h1F.
- Sync mode: write CTRL=1; write 5/6/7 to the three channels -> color_out stays 0. Write CTRL=3 -> STATUS=1. Raise vblank -> at that edge color_out=12'h765 and STATUS=0.
- Simultaneous events: with PENDING=1 and shadow0=5, write 9 to shadow0 in the vblank-rise cycle -> channel 0 active=5, shadow0 reads 9, PENDING=0. Also, COMMIT written in the tick cycle -> commit occurs and PENDING=0.
- Frame counter: with MM_VGA_FRAME_IRQ_EN defined and CTRL=4, 3 vblank pulses -> FRAME=3 and three single-cycle frame_irq pulses. Repeat with the macro undefined -> FRAME=0 and frame_irq constantly 0.
- Reset with PENDING=1 and vblank held high -> after release, no commit, no tick, FRAME=0. Write 32'h80000010 -> no register changes.
